// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (also used by the transmitter),
// frame data width, and the 3-sample majority vote helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_oversample_tick.sv
// Free-running oversample tick generator: a one-cycle enable every TICK_DIV
// clocks. It is a clock enable, not a derived clock.
module uart_oversample_tick #(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int TICK_DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int CNT_W    = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap   = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign tick_o = wrap;

  // Next count: wrap to zero after TICK_DIV-1.
  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, per-frame phase reset and
// majority-vote bit sampling. Bytes are handed out on a valid/ready port.
//
// Handshake: data is presented with valid=1 and held stable until a rising
// clk edge sees valid&ready; a byte that completes on that same edge replaces
// it and keeps valid high. A byte completing while valid=1 and ready=0 is
// dropped and reported by a one-cycle overrun pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frameErr,
  output logic                 overrun,
  output logic                 busy
);

  // Sample positions within a bit (bit centre -1, centre, +1) and last tick.
  localparam logic [3:0] CNT_LO   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] CNT_MID  = 4'(OVERSAMPLE / 2);
  localparam logic [3:0] CNT_HI   = 4'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

  logic                 tick;
  logic                 sync1_q, rx_s_q;
  logic                 prev_q, prev_d;
  uart_state_e          state_q, state_d;
  logic [3:0]           sample_cnt_q, sample_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 s7_q, s7_d, s8_q, s8_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 maj;

  uart_oversample_tick #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  assign maj      = maj3(s7_q, s8_q, rx_s_q);
  assign data     = data_q;
  assign valid    = valid_q;
  assign frameErr = frame_err_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != ST_IDLE);

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
    end
  end

  // Next-state logic: frame FSM, sampling, shift register and handshake.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    sample_cnt_d = sample_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    s7_d         = s7_q;
    s8_d         = s8_q;
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;

    if (valid_q && ready) valid_d = 1'b0;

    if (tick) begin
      prev_d = rx_s_q;
      if (state_q != ST_IDLE) begin
        if (sample_cnt_q == CNT_LO)  s7_d = rx_s_q;
        if (sample_cnt_q == CNT_MID) s8_d = rx_s_q;
        sample_cnt_d = (sample_cnt_q == CNT_LAST) ? 4'd0 : sample_cnt_q + 4'd1;
      end

      case (state_q)
        ST_IDLE: begin
          // Falling edge between ticks; the detecting tick is sample 0.
          if (!rx_s_q && prev_q) begin
            state_d      = ST_START;
            sample_cnt_d = 4'd1;
          end
        end
        ST_START: begin
          if (sample_cnt_q == CNT_HI && maj) begin
            state_d = ST_IDLE;
          end else if (sample_cnt_q == CNT_LAST) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end
        end
        ST_DATA: begin
          if (sample_cnt_q == CNT_HI) shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (sample_cnt_q == CNT_LAST) begin
            if (bit_idx_q == IDX_LAST) state_d = ST_STOP;
            else                       bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        ST_STOP: begin
          // Decide mid-stop-bit so a back-to-back start edge is not missed.
          if (sample_cnt_q == CNT_HI) begin
            state_d = ST_IDLE;
            if (!maj) begin
              frame_err_d = 1'b1;
            end else if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      prev_q       <= 1'b1;
      sample_cnt_q <= 4'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= '0;
      s7_q         <= 1'b0;
      s8_q         <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      sample_cnt_q <= sample_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      s7_q         <= s7_d;
      s8_q         <= s8_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at TICK_DIV=10 (160 clk per bit).
module tb_uart_rx;

  localparam int BIT_CLK = 160;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int valid_rise_cyc = 0;
  int vhigh_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic valid_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  uart_rx #(
    .CLOCK_RATE (1600000),
    .BAUD_RATE  (10000),
    .OVERSAMPLE (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frameErr (frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: compare each accepted byte with the oldest expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) vhigh_cnt++;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (valid && !valid_prev) valid_rise_cyc = cyc;
      if (valid && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got data=%h with empty expected queue", data);
        end else begin
          exp_b = exp_q.pop_front();
          if (data !== exp_b) begin
            errors++;
            $display("FAIL sb_data got %h expected %h", data, exp_b);
          end
        end
      end
    end
    valid_prev = valid;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog cycle budget expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Driver tasks.
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1;
    rx = 1'b0;
    start_cyc = cyc;
    hold(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(BIT_CLK);
    end
    rx = stop_bit;
    hold(BIT_CLK);
    rx = 1'b1;
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s pending expected bytes %0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Reset state.
  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; ready = 1'b0;
    hold(5);
    checks += 5;
    if (data !== 8'h00)    begin errors++; $display("FAIL rst_data got %h expected 00", data); end
    if (valid !== 1'b0)    begin errors++; $display("FAIL rst_valid got %b expected 0", valid); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frameErr got %b expected 0", frame_err); end
    if (overrun !== 1'b0)  begin errors++; $display("FAIL rst_overrun got %b expected 0", overrun); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got %b expected 0", busy); end
    rst = 1'b0;
    hold(20);
  endtask

  task automatic test_basic();
    int vh0, fe0, lat;
    ready = 1'b1;
    vh0 = vhigh_cnt; fe0 = fe_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    hold(40);
    check_sb_empty("basic_sb");
    lat = valid_rise_cyc - start_cyc;
    checks += 3;
    if (vhigh_cnt - vh0 !== 1) begin errors++; $display("FAIL basic_valid_cycles got %0d expected 1", vhigh_cnt - vh0); end
    if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL basic_frameErr got %0d pulses expected 0", fe_cnt - fe0); end
    if (lat < 1525 || lat > 1550) begin errors++; $display("FAIL basic_latency got %0d expected 1525..1550", lat); end
  endtask

  task automatic test_start_glitch();
    int vh0;
    vh0 = vhigh_cnt;
    @(posedge clk); #1;
    rx = 1'b0;
    hold(30);
    rx = 1'b1;
    hold(100);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b expected 0", busy); end
    if (vhigh_cnt - vh0 !== 0) begin errors++; $display("FAIL glitch_valid got %0d cycles expected 0", vhigh_cnt - vh0); end
    hold(50);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    hold(40);
    check_sb_empty("glitch_sb");
  endtask

  task automatic test_frame_err();
    int vh0, fe0;
    vh0 = vhigh_cnt; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    hold(200);
    checks += 2;
    if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_pulse got %0d cycles expected 1", fe_cnt - fe0); end
    if (vhigh_cnt - vh0 !== 0) begin errors++; $display("FAIL ferr_valid got %0d cycles expected 0", vhigh_cnt - vh0); end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    hold(40);
    check_sb_empty("ferr_sb");
  endtask

  // 0x00 frame with a one-tick high pulse on the centre sample of bit 3.
  task automatic test_majority();
    int fe0, ov0;
    logic found;
    fe0 = fe_cnt; ov0 = ov_cnt; found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dut.u_tick.tick_o) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL maj_align no tick seen got 0 expected 1"); end
    @(posedge clk); #1;
    exp_q.push_back(8'h00);
    rx = 1'b0;
    hold(727);
    rx = 1'b1;
    hold(10);
    rx = 1'b0;
    hold(703);
    rx = 1'b1;
    hold(BIT_CLK);
    hold(40);
    check_sb_empty("maj_sb");
    checks += 2;
    if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL maj_frameErr got %0d expected 0", fe_cnt - fe0); end
    if (ov_cnt - ov0 !== 0) begin errors++; $display("FAIL maj_overrun got %0d expected 0", ov_cnt - ov0); end
  endtask

  task automatic test_overrun();
    int ov0;
    ov0 = ov_cnt;
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    hold(40);
    checks += 3;
    if (valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b expected 1", valid); end
    if (data !== 8'h11) begin errors++; $display("FAIL ovr_data got %h expected 11", data); end
    if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL ovr_pulse got %0d cycles expected 1", ov_cnt - ov0); end
    ready = 1'b1;
    hold(1);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL ovr_accept valid got %b expected 0", valid); end
    check_sb_empty("ovr_sb");
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'hC3;
    ready = 1'b1;
    @(posedge clk); #1;
    rx = 1'b0;
    hold(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      hold(BIT_CLK);
    end
    rx = b[4];
    hold(80);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b expected 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks += 5;
    if (data !== 8'h00)    begin errors++; $display("FAIL mid_data got %h expected 00", data); end
    if (valid !== 1'b0)    begin errors++; $display("FAIL mid_valid got %b expected 0", valid); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL mid_frameErr got %b expected 0", frame_err); end
    if (overrun !== 1'b0)  begin errors++; $display("FAIL mid_overrun got %b expected 0", overrun); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL mid_busy got %b expected 0", busy); end
    rx = 1'b1;
    hold(3);
    rst = 1'b0;
    hold(50);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    hold(40);
    check_sb_empty("mid_sb");
    checks++;
    if (data !== 8'h5A) begin errors++; $display("FAIL mid_data_after got %h expected 5a", data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_glitch();
    test_frame_err();
    test_majority();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
